// File: rtl/bin2bcd_if.sv
// Request/response bundle between a binary source and the sequential BCD converter.
interface bin2bcd_if #(
   parameter int unsigned BIN_W = 16
);
   logic             start;
   logic [BIN_W-1:0] bin;
   logic             busy;
   logic             done;
   logic [15:0]      bcd;
   logic             ovf;

   modport master (output start, bin, input busy, done, bcd, ovf);
   modport slave  (input start, bin, output busy, done, bcd, ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to 4-digit packed BCD converter, one shift per clock.
// The ten-thousands digit is kept internally only to flag overflow.
module bin2bcd_seq #(
   parameter int unsigned BIN_W = 16
) (
   input  logic      clk,
   input  logic      rst_n,
   bin2bcd_if.slave  bus
);
   localparam int unsigned ACC_W  = 20;
   localparam int unsigned DIGITS = ACC_W / 4;
   localparam int unsigned CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [BIN_W-1:0] sh_q, sh_d;
   logic [ACC_W-1:0] acc_q, acc_d, acc_adj;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [15:0]      bcd_q, bcd_d;
   logic             ovf_q, ovf_d;

   // Add 3 to every digit >= 5 so the following shift carries correctly into the next digit.
   function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] a);
      logic [ACC_W-1:0] r;
      logic [3:0]       d;
      r = a;
      for (int i = 0; i < int'(DIGITS); i++) begin
         d = a[4*i +: 4];
         if (d >= 4'd5) d = d + 4'd3;
         r[4*i +: 4] = d;
      end
      return r;
   endfunction

   assign acc_adj = add3(acc_q);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sh_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         bcd_q   <= 16'h0000;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (bus.start) begin
               sh_d    = bus.bin;
               acc_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            acc_d = {acc_adj[ACC_W-2:0], sh_q[BIN_W-1]};
            sh_d  = {sh_q[BIN_W-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_W - 1)) state_d = DONE;
         end
         DONE: begin
            bcd_d   = acc_q[15:0];
            ovf_d   = |acc_q[ACC_W-1:16];
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.bcd  = bcd_q;
   assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: driver queues expected results, a monitor checks each done pulse.
module tb_bin2bcd_seq;
   localparam int unsigned BIN_W = 16;
   localparam int LAT = BIN_W + 1;

   typedef struct {
      logic [15:0] bcd;
      logic        ovf;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   logic [15:0] last_bcd;
   logic        last_ovf;

   bin2bcd_if #(.BIN_W(BIN_W)) bif ();

   bin2bcd_seq #(.BIN_W(BIN_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h at cycle %0d", name, got, want, cyc);
      end
   endtask

   // Reference: decimal digits by division, independent of the shift/add-3 scheme.
   function automatic logic [16:0] model(input int unsigned v);
      int unsigned m;
      m = v % 10000;
      return {(v > 9999) ? 1'b1 : 1'b0, 4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   task automatic push(input logic [16:0] e, input int start_edge);
      exp_t x;
      x.ovf = e[16];
      x.bcd = e[15:0];
      x.cyc = start_edge + LAT;
      exp_q.push_back(x);
   endtask

   task automatic monitor();
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            last_bcd = 16'h0000;
            last_ovf = 1'b0;
         end else if (bif.done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'(bif.bcd), 32'hFFFF_FFFF);
            end else begin
               x = exp_q.pop_front();
               chk("bcd", 32'(bif.bcd), 32'(x.bcd));
               chk("ovf", 32'(bif.ovf), 32'(x.ovf));
               chk("done_cycle", 32'(cyc), 32'(x.cyc));
               for (int i = 0; i < 4; i++)
                  chk("nibble_le9", 32'(bif.bcd[4*i +: 4] <= 4'd9), 32'd1);
            end
            last_bcd = bif.bcd;
            last_ovf = bif.ovf;
         end else begin
            chk("bcd_held", 32'({bif.ovf, bif.bcd}), 32'({last_ovf, last_bcd}));
         end
      end
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 60; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // One conversion; also measures how many cycles busy stays high.
   task automatic do_conv(input logic [15:0] v, input logic [16:0] e);
      int n;
      @(negedge clk);
      bif.start = 1'b1;
      bif.bin   = BIN_W'(v);
      push(e, cyc + 1);
      @(posedge clk);
      #1;
      bif.start = 1'b0;
      n = 0;
      while (bif.busy && n < 40) begin
         n++;
         @(posedge clk);
         #1;
      end
      chk("busy_cycles", 32'(n), 32'(LAT));
      drain();
   endtask

   initial begin
      int base;
      logic [15:0] rv;
      rst_n     = 1'b0;
      bif.start = 1'b0;
      bif.bin   = '0;
      last_bcd  = 16'h0000;
      last_ovf  = 1'b0;
      fork
         monitor();
      join_none
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bif.busy), 32'd0);
      chk("rst_done", 32'(bif.done), 32'd0);
      chk("rst_bcd",  32'(bif.bcd),  32'h0);
      chk("rst_ovf",  32'(bif.ovf),  32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed vectors with hand-computed results {ovf, bcd}.
      do_conv(16'd1234,  {1'b0, 16'h1234});
      do_conv(16'd0,     {1'b0, 16'h0000});
      do_conv(16'd9999,  {1'b0, 16'h9999});
      do_conv(16'd10000, {1'b1, 16'h0000});
      do_conv(16'd65535, {1'b1, 16'h5535});
      do_conv(16'd10,    {1'b0, 16'h0010});
      do_conv(16'd5059,  {1'b0, 16'h5059});
      do_conv(16'd20481, {1'b1, 16'h0481});

      // Starts while busy are ignored; start held through done begins the next conversion.
      @(negedge clk);
      bif.start = 1'b1;
      bif.bin   = 16'd42;
      base = cyc + 1;
      push({1'b0, 16'h0042}, base);
      @(negedge clk);
      bif.start = 1'b0;
      wait_until(base + 4);
      bif.start = 1'b1;
      bif.bin   = 16'd777;
      @(negedge clk);
      bif.start = 1'b0;
      wait_until(base + 16);
      bif.start = 1'b1;
      push({1'b0, 16'h0777}, base + LAT + 1);
      @(negedge clk);
      @(negedge clk);
      bif.start = 1'b0;
      drain();

      // Reset in the middle of a conversion discards it.
      @(negedge clk);
      bif.start = 1'b1;
      bif.bin   = 16'd4321;
      base = cyc + 1;
      @(negedge clk);
      bif.start = 1'b0;
      wait_until(base + 7);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_busy", 32'(bif.busy), 32'd0);
      chk("abort_bcd",  32'(bif.bcd),  32'h0);
      chk("abort_ovf",  32'(bif.ovf),  32'd0);
      chk("abort_done", 32'(bif.done), 32'd0);
      repeat (25) @(negedge clk);
      do_conv(16'd4321, {1'b0, 16'h4321});

      // Random values against the division-based model.
      for (int i = 0; i < 1000; i++) begin
         rv = 16'($urandom_range(0, 65535));
         do_conv(rv, model(32'(rv)));
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
